// File: rtl/video_axis_pkg.sv
// Shared types for the AXI4-Stream video receive/transmit path.
package video_axis_pkg;
  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DISCARD  = 2'd2
  } rx_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry elastic stage with a registered ready; the consumer pops from the head.
module axis_skid_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             i_clk,
  input  logic             i_areset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_pop
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  assign push    = s_valid && s_ready;
  assign m_valid = (count != 2'd0);
  assign pop     = m_pop && m_valid;
  assign m_data  = mem[rd_ptr];

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // ready is computed from the post-edge occupancy so it can be a flop
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      s_ready <= (count_next != 2'd2);
    end
  end
endmodule

// File: rtl/s_axis_video_rx.sv
// AXI4-Stream video slave: strips tuser/tlast framing, attaches x/y and flags geometry errors.
//   state    | meaning
//   WAIT_SOF | dropping beats until a tuser beat starts a frame
//   ACTIVE   | forwarding pixels of the current line
//   DISCARD  | line overran its width; dropping through the next tlast
module s_axis_video_rx
  import video_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_pixel_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_line,
  output logic [COORD_W-1:0]    o_x,
  output logic [COORD_W-1:0]    o_y,
  output logic                  o_frame_done,
  output logic                  o_err_early_eol,
  output logic                  o_err_late_eol,
  output logic                  o_err_sof
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH+1:0] sk_data;
  logic                  sk_valid;
  logic                  sk_pop;
  logic                  beat_user;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] beat_data;

  axis_skid_buffer #(.WIDTH(DATA_WIDTH + 2)) u_skid (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .s_data   ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .s_valid  (s_axis_tvalid),
    .s_ready  (s_axis_tready),
    .m_data   (sk_data),
    .m_valid  (sk_valid),
    .m_pop    (sk_pop)
  );

  assign beat_user = sk_data[DATA_WIDTH+1];
  assign beat_last = sk_data[DATA_WIDTH];
  assign beat_data = sk_data[DATA_WIDTH-1:0];

  rx_state_t          state, state_nxt;
  logic [COORD_W-1:0] x, y, x_nxt, y_nxt, cx, cy;
  logic               out_ok, fwd, drop, eol, eof, early, late, disc_done;
  logic               out_eof;

  assign out_ok = !o_pixel_valid || i_ready;
  assign sk_pop = fwd || drop;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    cx        = x;
    cy        = y;
    fwd       = 1'b0;
    drop      = 1'b0;
    eol       = 1'b0;
    eof       = 1'b0;
    early     = 1'b0;
    late      = 1'b0;
    disc_done = 1'b0;
    if (sk_valid) begin
      if (beat_user || state == ACTIVE) begin
        // a forwarded beat waits in the skid stage until the output register frees up
        if (out_ok) begin
          fwd = 1'b1;
          if (beat_user) begin
            cx = '0;
            cy = '0;
          end
          if (beat_last) begin
            eol   = 1'b1;
            early = (cx != X_LAST);
            x_nxt = '0;
            if (cy == Y_LAST) begin
              eof       = 1'b1;
              y_nxt     = '0;
              state_nxt = WAIT_SOF;
            end else begin
              y_nxt     = cy + COORD_W'(1);
              state_nxt = ACTIVE;
            end
          end else if (cx == X_LAST) begin
            eol       = 1'b1;
            late      = 1'b1;
            x_nxt     = cx;
            y_nxt     = cy;
            state_nxt = DISCARD;
          end else begin
            x_nxt     = cx + COORD_W'(1);
            y_nxt     = cy;
            state_nxt = ACTIVE;
          end
        end
      end else begin
        drop = 1'b1;
        if (state == DISCARD && beat_last) begin
          x_nxt = '0;
          if (y == Y_LAST) begin
            disc_done = 1'b1;
            y_nxt     = '0;
            state_nxt = WAIT_SOF;
          end else begin
            y_nxt     = y + COORD_W'(1);
            state_nxt = ACTIVE;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state            <= WAIT_SOF;
      x                <= '0;
      y                <= '0;
      o_pixel          <= '0;
      o_pixel_valid    <= 1'b0;
      o_start_of_frame <= 1'b0;
      o_end_of_line    <= 1'b0;
      o_x              <= '0;
      o_y              <= '0;
      out_eof          <= 1'b0;
      o_frame_done     <= 1'b0;
      o_err_early_eol  <= 1'b0;
      o_err_late_eol   <= 1'b0;
      o_err_sof        <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      if (fwd) begin
        o_pixel          <= beat_data;
        o_pixel_valid    <= 1'b1;
        o_start_of_frame <= beat_user;
        o_end_of_line    <= eol;
        o_x              <= cx;
        o_y              <= cy;
        out_eof          <= eof;
      end else if (i_ready) begin
        o_pixel_valid <= 1'b0;
      end
      o_frame_done    <= (o_pixel_valid && i_ready && out_eof) || disc_done;
      o_err_early_eol <= early;
      o_err_late_eol  <= late;
      o_err_sof       <= fwd && beat_user && (state != WAIT_SOF);
    end
  end
endmodule

// File: tb/tb_s_axis_video_rx.sv
// Self-checking bench for s_axis_video_rx against a frame-level reference model.
module tb_s_axis_video_rx;
  localparam int DW = 32;
  localparam int W  = 10;
  localparam int H  = 10;

  logic          i_clk = 1'b0;
  logic          i_areset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_pixel;
  logic          o_pixel_valid, o_start_of_frame, o_end_of_line;
  logic [11:0]   o_x, o_y;
  logic          o_frame_done, o_err_early_eol, o_err_late_eol, o_err_sof;

  always #5 i_clk = ~i_clk;

  s_axis_video_rx #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(i_clk), .i_areset(i_areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .i_ready(i_ready),
    .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_start_of_frame(o_start_of_frame),
    .o_end_of_line(o_end_of_line), .o_x(o_x), .o_y(o_y), .o_frame_done(o_frame_done),
    .o_err_early_eol(o_err_early_eol), .o_err_late_eol(o_err_late_eol), .o_err_sof(o_err_sof)
  );

  typedef struct { logic user; logic last; logic [DW-1:0] data; } beat_t;
  typedef struct { logic [DW-1:0] data; int x; int y; logic sof, eol, early, late, esof; } pix_t;

  beat_t src_q[$];
  pix_t  exp_q[$];
  int n_assert = 0, n_fail = 0;
  int mode = 0, mx = 0, my = 0;   // 0: idle, 1: in frame, 2: skipping rest of line
  int tvalid_pct = 100, ready_pct = 100;
  int cyc = 0, first_acc = -1, first_val = -1;
  int npix, n_done, n_early, n_late, n_sof;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix_vec(input pix_t p);
    return {6'd0, p.data, 12'(p.x), 12'(p.y), p.sof, p.eol};
  endfunction

  // Reference: framing rules applied to each accepted beat in order.
  task automatic model_beat(input beat_t b);
    pix_t p;
    logic resync;
    resync = 1'b0;
    if (b.user) begin
      resync = (mode != 0);
      mode = 1; mx = 0; my = 0;
    end else if (mode == 0) begin
      return;
    end else if (mode == 2) begin
      if (b.last) begin
        mx = 0; my++;
        if (my == H) begin mode = 0; my = 0; end
        else mode = 1;
      end
      return;
    end
    p.data = b.data; p.x = mx; p.y = my; p.sof = b.user; p.esof = resync;
    p.eol   = b.last || (mx == W - 1);
    p.early = b.last && (mx != W - 1);
    p.late  = !b.last && (mx == W - 1);
    exp_q.push_back(p);
    if (b.last) begin
      mx = 0; my++;
      if (my == H) begin mode = 0; my = 0; end
    end else if (mx == W - 1) mode = 2;
    else mx++;
  endtask

  task automatic add_beats(input logic sof, input int n, input logic with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.user = sof && (i == 0);
      b.last = with_last && (i == n - 1);
      b.data = $urandom;
      src_q.push_back(b);
    end
  endtask

  task automatic add_frame();
    for (int r = 0; r < H; r++) add_beats(r == 0, W, 1'b1);
  endtask

  // One clock: drive at the falling edge, observe at the next falling edge.
  task automatic tick();
    logic acc, oacc, stalled, was_valid, newpix;
    logic [63:0] snap;
    logic [2:0] expf;
    beat_t b;
    pix_t e;
    if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(0, 99) < tvalid_pct) begin
      b = src_q[0];
      s_axis_tvalid = 1'b1; s_axis_tuser = b.user; s_axis_tlast = b.last; s_axis_tdata = b.data;
    end
    i_ready   = ($urandom_range(0, 99) < ready_pct);
    acc       = s_axis_tvalid && s_axis_tready;
    oacc      = o_pixel_valid && i_ready;
    stalled   = o_pixel_valid && !i_ready;
    was_valid = o_pixel_valid;
    snap      = {6'd0, o_pixel, o_x, o_y, o_start_of_frame, o_end_of_line};
    @(posedge i_clk); #1;
    cyc++;
    if (acc) begin
      b = src_q.pop_front();
      model_beat(b);
      s_axis_tvalid = 1'b0;
      if (first_acc < 0) first_acc = cyc;
    end
    if (oacc) begin
      npix++;
      if (exp_q.size() == 0) check("extra_pixel", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("pixel", snap, pix_vec(e));
      end
    end
    @(negedge i_clk);
    if (stalled)
      check("stall_hold", {o_pixel_valid, 5'd0, o_pixel, o_x, o_y, o_start_of_frame, o_end_of_line},
            {1'b1, snap[62:0]});
    newpix = o_pixel_valid && (!was_valid || oacc);
    expf = 3'b000;
    if (newpix && exp_q.size() > 0) expf = {exp_q[0].early, exp_q[0].late, exp_q[0].esof};
    check("err_flags", {o_err_early_eol, o_err_late_eol, o_err_sof}, expf);
    if (o_frame_done) n_done++;
    if (o_err_early_eol) n_early++;
    if (o_err_late_eol) n_late++;
    if (o_err_sof) n_sof++;
    if (first_val < 0 && o_pixel_valid) first_val = cyc;
  endtask

  task automatic start_scenario(input int vpct, input int rpct);
    tvalid_pct = vpct; ready_pct = rpct;
    npix = 0; n_done = 0; n_early = 0; n_late = 0; n_sof = 0;
  endtask

  task automatic drain_and_check(input string tag, input int epix, input int edone,
                                 input int eearly, input int elate, input int esof);
    int guard;
    guard = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || o_pixel_valid) && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_timeout"}, 64'(guard < 3000), 64'd1);
    repeat (4) tick();
    check({tag, "_pixels"}, 64'(npix), 64'(epix));
    check({tag, "_frame_done"}, 64'(n_done), 64'(edone));
    check({tag, "_early_eol"}, 64'(n_early), 64'(eearly));
    check({tag, "_late_eol"}, 64'(n_late), 64'(elate));
    check({tag, "_err_sof"}, 64'(n_sof), 64'(esof));
  endtask

  function automatic logic [63:0] all_outs();
    return {s_axis_tready, o_pixel, o_pixel_valid, o_start_of_frame, o_end_of_line,
            o_x[7:0], o_y[7:0], o_frame_done, o_err_early_eol, o_err_late_eol, o_err_sof};
  endfunction

  initial begin
    int guard;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", all_outs(), 64'd0);
    i_areset = 1'b0;
    #1 check("tready_before_edge", 64'(s_axis_tready), 64'd0);
    @(negedge i_clk);
    check("tready_after_release", 64'(s_axis_tready), 64'd1);

    // clean frame, full throughput
    start_scenario(100, 100);
    first_acc = -1; first_val = -1;
    add_frame();
    drain_and_check("clean", W * H, 1, 0, 0, 0);
    check("latency", 64'(first_val - first_acc), 64'd1);

    // random tvalid and backpressure
    start_scenario(70, 50);
    add_frame();
    drain_and_check("stall", W * H, 1, 0, 0, 0);

    // early tlast at x=6 on line 3
    start_scenario(80, 80);
    for (int r = 0; r < H; r++) add_beats(r == 0, (r == 3) ? 7 : W, 1'b1);
    drain_and_check("early", W * H - 3, 1, 1, 0, 0);

    // line 2 overruns to 13 beats
    start_scenario(80, 70);
    for (int r = 0; r < H; r++) add_beats(r == 0, (r == 2) ? 13 : W, 1'b1);
    drain_and_check("late", W * H, 1, 0, 1, 0);

    // orphan beats before the first tuser
    start_scenario(90, 90);
    add_beats(1'b0, 5, 1'b0);
    add_frame();
    drain_and_check("orphan", W * H, 1, 0, 0, 0);

    // second tuser at (4,5)
    start_scenario(75, 75);
    for (int r = 0; r < 5; r++) add_beats(r == 0, W, 1'b1);
    add_beats(1'b0, 4, 1'b0);
    add_frame();
    drain_and_check("resof", 5 * W + 4 + W * H, 1, 0, 0, 1);

    // reset pulse at (3,2)
    start_scenario(100, 100);
    add_beats(1'b1, W, 1'b1);
    add_beats(1'b0, W, 1'b1);
    add_beats(1'b0, 3, 1'b0);
    guard = 0;
    while (src_q.size() > 0 && guard < 200) begin tick(); guard++; end
    check("pre_reset_timeout", 64'(guard < 200), 64'd1);
    tick();
    i_areset = 1'b1;
    #1 check("midframe_reset_outputs", all_outs(), 64'd0);
    s_axis_tvalid = 1'b0;
    src_q.delete(); exp_q.delete();
    mode = 0; mx = 0; my = 0;
    repeat (2) @(negedge i_clk);
    check("held_reset_outputs", all_outs(), 64'd0);
    i_areset = 1'b0;
    @(negedge i_clk);
    start_scenario(90, 80);
    add_beats(1'b0, 4, 1'b0);
    add_beats(1'b0, 3, 1'b1);
    add_frame();
    drain_and_check("reset", W * H, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
